// File: rtl/spi_seq_pkg.sv
// Shared constants and state encodings for the SPI register-port sequencer.
package spi_seq_pkg;

    localparam logic [2:0] AddrRxData   = 3'd0;
    localparam logic [2:0] AddrTxData   = 3'd1;
    localparam logic [2:0] AddrStatus   = 3'd2;
    localparam logic [2:0] AddrControl  = 3'd3;
    localparam logic [2:0] AddrSlaveSel = 3'd5;

    localparam int unsigned StatRrdy = 7;
    localparam int unsigned StatErr  = 8;

    localparam logic [15:0] CtrlSso = 16'h0400;

    typedef enum logic [3:0] {
        StIdle,
        StClrSt,
        StWrSs,
        StSsoOn,
        StWaitByte,
        StWrTx,
        StPoll,
        StRdRx,
        StSsoOff
    } seq_state_e;

    typedef enum logic [1:0] {
        BusIdle,
        BusCyc1,
        BusCyc2,
        BusGap
    } bus_state_e;

endpackage

// File: rtl/spi_seq_bus_access.sv
// Two-cycle register access engine for the SPI master port, with a mandatory idle
// cycle after each access (done pulses during that idle cycle).
module spi_seq_bus_access
    import spi_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        wr,
    input  logic [2:0]  addr,
    input  logic [15:0] wdata,
    output logic        done,
    output logic [15:0] rdata,
    output logic        spi_select,
    output logic [2:0]  mem_addr,
    output logic        read_n,
    output logic        write_n,
    output logic [15:0] data_from_cpu,
    input  logic [15:0] data_to_cpu
);

    bus_state_e  state_q, state_d;
    logic        wr_q, wr_d;
    logic [2:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        active;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= BusIdle;
            wr_q    <= 1'b0;
            addr_q  <= 3'd0;
            wdata_q <= 16'h0;
            rdata_q <= 16'h0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        unique case (state_q)
            BusIdle: begin
                if (start) begin
                    state_d = BusCyc1;
                    wr_d    = wr;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            BusCyc1: state_d = BusCyc2;
            BusCyc2: begin
                state_d = BusGap;
                if (!wr_q) rdata_d = data_to_cpu;
            end
            BusGap:  state_d = BusIdle;
            default: state_d = BusIdle;
        endcase
    end

    always_comb begin
        active        = (state_q == BusCyc1) || (state_q == BusCyc2);
        spi_select    = active;
        read_n        = !(active && !wr_q);
        write_n       = !(active && wr_q);
        mem_addr      = addr_q;
        data_from_cpu = wdata_q;
        done          = (state_q == BusGap);
        rdata         = rdata_q;
    end

endmodule

// File: rtl/spi_seq_arbiter.sv
// Round-robin arbiter and register-access sequencer that runs byte bursts through
// the SPI master's register port on behalf of NUM_REQ requesters.
module spi_seq_arbiter
    import spi_seq_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned SS_W       = 1,
    parameter int unsigned POLL_LIMIT = 4096,
    parameter int unsigned PCNT_W     = 13
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [8*NUM_REQ-1:0]      req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    input  logic [SS_W*NUM_REQ-1:0]   req_ss,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [7:0]                rsp_data,
    output logic                      rsp_err,
    output logic                      busy,
    output logic                      spi_select,
    output logic [2:0]                mem_addr,
    output logic                      read_n,
    output logic                      write_n,
    output logic [15:0]               data_from_cpu,
    input  logic [15:0]               data_to_cpu
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    seq_state_e         state_q, state_d;
    logic [IdxW-1:0]    grant_q, grant_d, rr_q, rr_d;
    logic [SS_W-1:0]    ss_q, ss_d;
    logic [7:0]         byte_q, byte_d;
    logic               last_q, last_d, err_q, err_d, pend_q, pend_d;
    logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;

    logic               bus_start, bus_wr, bus_done;
    logic [2:0]         bus_addr;
    logic [15:0]        bus_wdata, bus_rdata;
    logic               pick_found;
    logic [IdxW-1:0]    pick_idx, cand;
    logic               unused_rdata_hi;

    assign unused_rdata_hi = ^bus_rdata[15:9];

    spi_seq_bus_access u_bus (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (bus_start),
        .wr            (bus_wr),
        .addr          (bus_addr),
        .wdata         (bus_wdata),
        .done          (bus_done),
        .rdata         (bus_rdata),
        .spi_select    (spi_select),
        .mem_addr      (mem_addr),
        .read_n        (read_n),
        .write_n       (write_n),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            rr_q        <= '0;
            ss_q        <= '0;
            byte_q      <= 8'h0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            pcnt_q      <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= 8'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            rr_q        <= rr_d;
            ss_q        <= ss_d;
            byte_q      <= byte_d;
            last_q      <= last_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            pcnt_q      <= pcnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // First valid requester at or after the round-robin pointer.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = rr_q;
        cand       = rr_q;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = IdxW'((32'(rr_q) + k) % NUM_REQ);
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_d        = rr_q;
        ss_d        = ss_q;
        byte_d      = byte_q;
        last_d      = last_q;
        err_d       = err_q;
        pcnt_d      = pcnt_q;
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        pend_d      = bus_done ? 1'b0 : (bus_start ? 1'b1 : pend_q);
        unique case (state_q)
            StIdle: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    ss_d    = req_ss[32'(pick_idx)*SS_W +: SS_W];
                    state_d = StClrSt;
                end
            end
            StClrSt: if (bus_done) state_d = StWrSs;
            StWrSs:  if (bus_done) state_d = StSsoOn;
            StSsoOn: if (bus_done) state_d = StWaitByte;
            StWaitByte: begin
                if (req_valid[grant_q]) begin
                    byte_d  = req_data[32'(grant_q)*8 +: 8];
                    last_d  = req_last[grant_q];
                    pcnt_d  = '0;
                    state_d = StWrTx;
                end
            end
            StWrTx: if (bus_done) state_d = StPoll;
            StPoll: begin
                if (bus_done) begin
                    if (bus_rdata[StatRrdy] || bus_rdata[StatErr]) begin
                        err_d   = err_q | bus_rdata[StatErr];
                        state_d = StRdRx;
                    end else if (pcnt_q == PCNT_W'(POLL_LIMIT - 1)) begin
                        // Timed out: report a zero byte and close the burst.
                        err_d                = 1'b1;
                        rsp_valid_d[grant_q] = 1'b1;
                        rsp_data_d           = 8'h0;
                        rsp_err_d            = 1'b1;
                        state_d              = StSsoOff;
                    end else begin
                        pcnt_d = pcnt_q + PCNT_W'(1);
                    end
                end
            end
            StRdRx: begin
                if (bus_done) begin
                    rsp_valid_d[grant_q] = 1'b1;
                    rsp_data_d           = bus_rdata[7:0];
                    rsp_err_d            = err_q;
                    state_d              = (last_q || err_q) ? StSsoOff : StWaitByte;
                end
            end
            StSsoOff: begin
                if (bus_done) begin
                    rr_d    = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + IdxW'(1);
                    err_d   = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        req_ready = '0;
        rsp_valid = rsp_valid_q;
        rsp_data  = rsp_data_q;
        rsp_err   = rsp_err_q;
        bus_start = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = AddrRxData;
        bus_wdata = 16'h0;
        unique case (state_q)
            StClrSt: begin
                bus_start = !pend_q;
                bus_wr    = 1'b1;
                bus_addr  = AddrStatus;
            end
            StWrSs: begin
                bus_start = !pend_q;
                bus_wr    = 1'b1;
                bus_addr  = AddrSlaveSel;
                bus_wdata = 16'(ss_q);
            end
            StSsoOn: begin
                bus_start = !pend_q;
                bus_wr    = 1'b1;
                bus_addr  = AddrControl;
                bus_wdata = CtrlSso;
            end
            StWaitByte: req_ready[grant_q] = req_valid[grant_q];
            StWrTx: begin
                bus_start = !pend_q;
                bus_wr    = 1'b1;
                bus_addr  = AddrTxData;
                bus_wdata = {8'h0, byte_q};
            end
            StPoll: begin
                bus_start = !pend_q;
                bus_addr  = AddrStatus;
            end
            StRdRx: bus_start = !pend_q;
            StSsoOff: begin
                bus_start = !pend_q;
                bus_wr    = 1'b1;
                bus_addr  = AddrControl;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_seq_arbiter.sv
// Directed bench: stub SPI master with loopback, bus protocol monitor and burst checks.
module tb_spi_seq_arbiter;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req_valid, req_last, req_ss, req_ready, rsp_valid;
    logic [15:0] req_data;
    logic [7:0]  rsp_data;
    logic        rsp_err, busy, spi_select, read_n, write_n;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu, data_to_cpu;

    spi_seq_arbiter #(
        .NUM_REQ    (2),
        .SS_W       (1),
        .POLL_LIMIT (8),
        .PCNT_W     (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ss        (req_ss),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_err       (rsp_err),
        .busy          (busy),
        .spi_select    (spi_select),
        .mem_addr      (mem_addr),
        .read_n        (read_n),
        .write_n       (write_n),
        .data_from_cpu (data_from_cpu),
        .data_to_cpu   (data_to_cpu)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          viol = 0;
    int          len = 0;
    int          ss_rise = 0;
    logic        ss_prev = 1'b1;
    logic [19:0] snap;
    logic [19:0] trace[$];
    logic [9:0]  rsps[$];
    logic [8:0]  fq0[$], fq1[$];
    logic [8:0]  h0, h1;
    logic [1:0]  ready_seen = 2'b00;
    bit          never_rrdy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stub SPI master: registered read data, RX loops back TX after a fixed delay.
    logic [7:0]  m_tx, m_rx;
    logic        m_rrdy;
    logic [15:0] m_ctrl;
    int          m_dly;
    wire         ss_n = !m_ctrl[10];

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_tx <= 8'h0; m_rx <= 8'h0; m_rrdy <= 1'b0; m_ctrl <= 16'h0;
            m_dly <= 0; data_to_cpu <= 16'h0;
        end else begin
            if (m_dly > 1) m_dly <= m_dly - 1;
            else if (m_dly == 1) begin
                m_dly <= 0;
                if (!never_rrdy) begin
                    m_rrdy <= 1'b1;
                    m_rx   <= m_tx;
                end
            end
            if (spi_select && !write_n) begin
                case (mem_addr)
                    3'd1: begin m_tx <= data_from_cpu[7:0]; m_rrdy <= 1'b0; m_dly <= 10; end
                    3'd3: m_ctrl <= data_from_cpu;
                    default: ;
                endcase
            end
            if (spi_select && !read_n) begin
                case (mem_addr)
                    3'd0: begin data_to_cpu <= {8'h0, m_rx}; m_rrdy <= 1'b0; end
                    3'd2: data_to_cpu <= {7'h0, 1'b0, m_rrdy, 7'h0};
                    default: data_to_cpu <= 16'h0;
                endcase
            end
        end
    end

    // Protocol monitor and trace/response capture.
    always @(negedge clk) begin
        if (!reset_n) begin
            len = 0;
        end else begin
            if ((spi_select || !read_n || !write_n) && !(spi_select && (read_n != write_n)))
                viol++;
            if (spi_select) begin
                if (len == 0) begin
                    snap = {!write_n, mem_addr, data_from_cpu};
                    trace.push_back({!write_n, mem_addr, write_n ? 16'h0 : data_from_cpu});
                end else if (snap != {!write_n, mem_addr, data_from_cpu}) begin
                    viol++;
                end
                len++;
                if (len > 2) viol++;
            end else begin
                if (len == 1) viol++;
                len = 0;
            end
            if ((req_ready & ~req_valid) != 2'b00) viol++;
            if ($countones(req_ready) > 1 || $countones(rsp_valid) > 1) viol++;
            for (int i = 0; i < 2; i++)
                if (rsp_valid[i]) rsps.push_back({1'(i), rsp_err, rsp_data});
            ready_seen = ready_seen | req_ready;
        end
        if (ss_n && !ss_prev) ss_rise++;
        ss_prev = ss_n;
    end

    // Requester feeders: present queue heads, pop on consumption.
    always @(posedge clk) begin
        #1;
        if (ready_seen[0] && fq0.size() > 0) void'(fq0.pop_front());
        if (ready_seen[1] && fq1.size() > 0) void'(fq1.pop_front());
        ready_seen = 2'b00;
        h0 = (fq0.size() > 0) ? fq0[0] : 9'h0;
        h1 = (fq1.size() > 0) ? fq1[0] : 9'h0;
        req_valid = {fq1.size() > 0, fq0.size() > 0};
        req_data  = {h1[7:0], h0[7:0]};
        req_last  = {h1[8], h0[8]};
    end

    function automatic logic [19:0] wr_e(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, a, d};
    endfunction

    function automatic logic [19:0] rd_e(input logic [2:0] a);
        return {1'b0, a, 16'h0};
    endfunction

    function automatic int count_tr(input logic [19:0] e);
        int c = 0;
        foreach (trace[k]) if (trace[k] == e) c++;
        return c;
    endfunction

    function automatic logic [19:0] tr_at(input int k);
        if (k >= 0 && k < trace.size()) return trace[k];
        return 20'hFFFFF;
    endfunction

    function automatic logic [9:0] rsp_at(input int k);
        if (k >= 0 && k < rsps.size()) return rsps[k];
        return 10'h3FF;
    endfunction

    task automatic clear_logs();
        trace.delete();
        rsps.delete();
        viol = 0;
        ss_rise = 0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_burst(input string tag);
        int n = 0;
        repeat (4) @(negedge clk);
        while ((busy || fq0.size() != 0 || fq1.size() != 0) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, n < 3000, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int  n;
        bit  found;
        req_valid = 2'b00; req_last = 2'b00; req_data = 16'h0; req_ss = 2'b11;

        repeat (3) @(negedge clk);
        check_eq("rst_read_n", read_n, 1);
        check_eq("rst_write_n", write_n, 1);
        check_eq("rst_select", spi_select, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_addr", mem_addr, 0);
        check_eq("rst_wdata", data_from_cpu, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_rsp_valid", rsp_valid, 0);
        check_eq("rst_rsp_data", rsp_data, 0);
        check_eq("rst_rsp_err", rsp_err, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single byte loopback with full bus trace.
        clear_logs();
        fq0.push_back({1'b1, 8'hA5});
        run_burst("t1_done");
        check_eq("t1_rsp_cnt", rsps.size(), 1);
        check_eq("t1_rsp", rsp_at(0), {1'b0, 1'b0, 8'hA5});
        check_eq("t1_trace_len", trace.size() >= 7, 1);
        check_eq("t1_tr0", tr_at(0), wr_e(3'd2, 16'h0000));
        check_eq("t1_tr1", tr_at(1), wr_e(3'd5, 16'h0001));
        check_eq("t1_tr2", tr_at(2), wr_e(3'd3, 16'h0400));
        check_eq("t1_tr3", tr_at(3), wr_e(3'd1, 16'h00A5));
        check_eq("t1_polls", count_tr(rd_e(3'd2)), trace.size() - 6);
        check_eq("t1_rdrx", tr_at(trace.size() - 2), rd_e(3'd0));
        check_eq("t1_sso_off", tr_at(trace.size() - 1), wr_e(3'd3, 16'h0000));
        check_eq("t1_proto", viol, 0);

        // Reset in the middle of status polling.
        clear_logs();
        fq1.push_back({1'b1, 8'h44});
        n = 0;
        found = 1'b0;
        while (!found && n < 400) begin
            @(negedge clk);
            n++;
            if (spi_select && !read_n && mem_addr == 3'd2) found = 1'b1;
        end
        check_eq("t5_reach_poll", found, 1);
        #2 reset_n = 1'b0;
        #1;
        check_eq("t5_read_n", read_n, 1);
        check_eq("t5_write_n", write_n, 1);
        check_eq("t5_select", spi_select, 0);
        check_eq("t5_busy", busy, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear_logs();
        fq0.push_back({1'b1, 8'h55});
        run_burst("t5_done");
        check_eq("t5_rsp_cnt", rsps.size(), 1);
        check_eq("t5_rsp", rsp_at(0), {1'b0, 1'b0, 8'h55});
        check_eq("t5_proto", viol, 0);

        // Round-robin: req0 re-requests but req1 wins, then order starts from req1.
        do_reset();
        clear_logs();
        fq0.push_back({1'b1, 8'h01});
        fq0.push_back({1'b1, 8'h03});
        fq1.push_back({1'b1, 8'h02});
        run_burst("t2a_done");
        check_eq("t2a_rsp_cnt", rsps.size(), 3);
        check_eq("t2a_rsp0", rsp_at(0), {1'b0, 1'b0, 8'h01});
        check_eq("t2a_rsp1", rsp_at(1), {1'b1, 1'b0, 8'h02});
        check_eq("t2a_rsp2", rsp_at(2), {1'b0, 1'b0, 8'h03});
        clear_logs();
        fq0.push_back({1'b1, 8'h05});
        fq1.push_back({1'b1, 8'h06});
        run_burst("t2b_done");
        check_eq("t2b_rsp_cnt", rsps.size(), 2);
        check_eq("t2b_rsp0", rsp_at(0), {1'b1, 1'b0, 8'h06});
        check_eq("t2b_rsp1", rsp_at(1), {1'b0, 1'b0, 8'h05});
        check_eq("t2_proto", viol, 0);

        // Three-byte burst keeps SS asserted throughout.
        clear_logs();
        fq1.push_back({1'b0, 8'h11});
        fq1.push_back({1'b0, 8'h22});
        fq1.push_back({1'b1, 8'h33});
        run_burst("t3_done");
        check_eq("t3_rsp_cnt", rsps.size(), 3);
        check_eq("t3_rsp0", rsp_at(0), {1'b1, 1'b0, 8'h11});
        check_eq("t3_rsp1", rsp_at(1), {1'b1, 1'b0, 8'h22});
        check_eq("t3_rsp2", rsp_at(2), {1'b1, 1'b0, 8'h33});
        check_eq("t3_sso_on", count_tr(wr_e(3'd3, 16'h0400)), 1);
        check_eq("t3_sso_off", count_tr(wr_e(3'd3, 16'h0000)), 1);
        check_eq("t3_tx_cnt", count_tr(wr_e(3'd1, 16'h0011)) + count_tr(wr_e(3'd1, 16'h0022))
                 + count_tr(wr_e(3'd1, 16'h0033)), 3);
        check_eq("t3_ss_rise", ss_rise, 1);
        check_eq("t3_proto", viol, 0);

        // RRDY never rises: exactly POLL_LIMIT status reads, then error response.
        clear_logs();
        never_rrdy = 1'b1;
        fq0.push_back({1'b1, 8'h77});
        run_burst("t4_done");
        never_rrdy = 1'b0;
        check_eq("t4_polls", count_tr(rd_e(3'd2)), 8);
        check_eq("t4_no_rdrx", count_tr(rd_e(3'd0)), 0);
        check_eq("t4_rsp_cnt", rsps.size(), 1);
        check_eq("t4_rsp", rsp_at(0), {1'b0, 1'b1, 8'h00});
        check_eq("t4_sso_off", tr_at(trace.size() - 1), wr_e(3'd3, 16'h0000));
        check_eq("t4_busy", busy, 0);
        check_eq("t4_proto", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
